// File: rtl/uart_reg_bridge.sv
// Command layer on top of a byte UART: parses W/R frames, drives a single-byte
// register bus, and returns one response byte per frame.
module uart_reg_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_err
);

  localparam int         CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_UNK = 8'h3F;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_CAP, SEND, WAIT_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    rsp_q, rsp_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_wdata_q, reg_wdata_d;
  logic          tx_start_q, tx_start_d;
  logic          reg_we_q, reg_we_d;
  logic          reg_re_q, reg_re_d;
  logic          busy_q, busy_d;
  logic          frame_err_q, frame_err_d;
  logic          is_cmd;
  logic          tmo;

  assign is_cmd = (rx_data == CMD_W) || (rx_data == CMD_R);
  // A byte arriving in the timeout cycle wins over the timeout.
  assign tmo    = !rx_valid && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      rsp_q       <= 8'h00;
      tx_data_q   <= 8'h00;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      tx_start_q  <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      rsp_q       <= rsp_d;
      tx_data_q   <= tx_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      tx_start_q  <= tx_start_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (rx_valid && !rx_error) state_d = is_cmd ? GET_ADDR : SEND;
      GET_ADDR:  if (rx_valid)              state_d = rx_error ? IDLE : (is_wr_q ? GET_DATA : REG_RD);
                 else if (tmo)              state_d = IDLE;
      GET_DATA:  if (rx_valid)              state_d = rx_error ? IDLE : REG_WR;
                 else if (tmo)              state_d = IDLE;
      REG_WR:                               state_d = SEND;
      REG_RD:                               state_d = RD_CAP;
      RD_CAP:                               state_d = SEND;
      SEND:      if (!tx_busy)              state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
    // Counter only runs while parked in a byte-wait state; any move clears it.
    cnt_d = '0;
    if ((state_q == GET_ADDR || state_q == GET_DATA) && state_d == state_q && !rx_valid)
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    is_wr_d     = is_wr_q;
    rsp_d       = rsp_q;
    tx_data_d   = tx_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    tx_start_d  = 1'b0;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_error)    frame_err_d = 1'b1;
        else if (is_cmd) is_wr_d     = (rx_data == CMD_W);
        else             rsp_d       = RSP_UNK;
      end
      GET_ADDR: if (rx_valid) begin
        if (rx_error) frame_err_d = 1'b1;
        else begin
          reg_addr_d = rx_data;
          reg_re_d   = !is_wr_q;
        end
      end else if (tmo) frame_err_d = 1'b1;
      GET_DATA: if (rx_valid) begin
        if (rx_error) frame_err_d = 1'b1;
        else begin
          reg_wdata_d = rx_data;
          reg_we_d    = 1'b1;
        end
      end else if (tmo) frame_err_d = 1'b1;
      REG_WR: rsp_d = RSP_OK;
      RD_CAP: rsp_d = reg_rdata;
      SEND: if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = rsp_q;
      end
      default: ;
    endcase
    // No byte buffering: anything arriving while a frame is being answered is lost.
    if (rx_valid && (state_q inside {REG_WR, REG_RD, RD_CAP, SEND, WAIT_DONE}))
      frame_err_d = 1'b1;
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: frame-level model schedules expected strobes per
// cycle; every cycle the DUT outputs are compared against that schedule.
module tb_uart_reg_bridge;
  localparam int T    = 16;
  localparam int MAXC = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, rx_error;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata;
  logic       busy, frame_err;

  uart_reg_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register file device: read data valid only in the cycle after reg_re.
  logic [7:0] rf [256];
  bit         seen [256];
  always @(posedge clk) begin
    if (reg_we) begin
      rf[reg_addr]   <= reg_wdata;
      seen[reg_addr] <= 1'b1;
    end
    reg_rdata <= reg_re ? (seen[reg_addr] ? rf[reg_addr] : (reg_addr ^ 8'hA5)) : 8'($urandom);
  end

  // Per-cycle expectations produced by the frame model.
  bit         e_we [MAXC];
  bit         e_re [MAXC];
  bit         e_start [MAXC];
  bit         e_ferr [MAXC];
  logic [7:0] e_addr [MAXC];
  logic [7:0] e_wd [MAXC];
  logic [7:0] e_data [MAXC];
  logic [7:0] mdl [256];
  logic [7:0] m_txd;
  bit         in_frame;
  bit         chk_en;
  int         cyc, checks, errors;
  int         last_n, last_we, last_re, last_st;
  logic [7:0] last_st_data;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  task automatic tick();
    bit was_rst;
    was_rst = !rst_n;
    @(posedge clk); #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (was_rst) m_txd = 8'h00;
    else if (e_start[cyc]) m_txd = e_data[cyc];
    if (reg_we) last_we = cyc;
    if (reg_re) last_re = cyc;
    if (tx_start) begin last_st = cyc; last_st_data = tx_data; end
    if (chk_en) begin
      chk("reg_we",    8'(reg_we),    8'(e_we[cyc]));
      chk("reg_re",    8'(reg_re),    8'(e_re[cyc]));
      chk("tx_start",  8'(tx_start),  8'(e_start[cyc]));
      chk("frame_err", 8'(frame_err), 8'(e_ferr[cyc]));
      chk("busy",      8'(busy),      8'(in_frame));
      chk("tx_data",   tx_data,       m_txd);
      if (e_we[cyc]) begin
        chk("we_addr",  reg_addr,  e_addr[cyc]);
        chk("we_wdata", reg_wdata, e_wd[cyc]);
      end
      if (e_re[cyc]) chk("re_addr", reg_addr, e_addr[cyc]);
    end
  endtask

  task automatic idle(input int g);
    repeat (g) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    rx_data = b; rx_valid = 1'b1; rx_error = err;
    tick();
    rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic abort_tmo();
    idle(T);
    in_frame = 1'b0;
    e_ferr[cyc+1] = 1'b1;
    tick();
  endtask

  task automatic abort_err(input logic [7:0] x);
    in_frame = 1'b0;
    e_ferr[cyc+1] = 1'b1;
    send(x, 1'b1);
  endtask

  // s: first cycle in which the response is ready to go; ovr: 0 none,
  // 1 random overrun cycle, 2 overrun with tx_done, 3 overrun at tx_start.
  task automatic respond(input int s, input logic [7:0] rsp, input int bp, input int dd, input int ovr);
    int p, q, ov;
    p = s + bp + 1;
    q = p + dd;
    e_start[p] = 1'b1;
    e_data[p]  = rsp;
    case (ovr)
      1:       ov = int'($urandom_range(q, cyc));
      2:       ov = q;
      3:       ov = p;
      default: ov = -1;
    endcase
    while (cyc <= q) begin
      tx_busy = (cyc != s + bp);
      tx_done = (cyc == q);
      if (cyc == q) in_frame = 1'b0;
      if (cyc == ov) begin
        rx_valid = 1'b1; rx_data = 8'($urandom); rx_error = 1'($urandom);
        e_ferr[cyc+1] = 1'b1;
      end
      tick();
      rx_valid = 1'b0; rx_error = 1'b0; tx_done = 1'b0;
    end
    tx_busy = 1'b0;
  endtask

  // ab: 0 none, 1 rx_error on addr, 2 rx_error on data, 3 timeout before addr, 4 timeout before data.
  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d,
                          input int g1, input int g2, input int bp, input int dd,
                          input int ovr, input int ab);
    int s;
    logic [7:0] rsp;
    in_frame = 1'b1;
    send(cmd, 1'b0);
    if (cmd != 8'h57 && cmd != 8'h52) begin
      last_n = cyc - 1; rsp = 8'h3F; s = cyc;
    end else begin
      if (ab == 3) begin abort_tmo(); return; end
      idle(g1);
      if (ab == 1) begin abort_err(a); return; end
      if (cmd == 8'h52) begin
        last_n = cyc; e_re[cyc+1] = 1'b1; e_addr[cyc+1] = a;
        rsp = mdl[a]; s = cyc + 3;
        send(a, 1'b0);
      end else begin
        send(a, 1'b0);
        if (ab == 4) begin abort_tmo(); return; end
        idle(g2);
        if (ab == 2) begin abort_err(d); return; end
        last_n = cyc; e_we[cyc+1] = 1'b1; e_addr[cyc+1] = a; e_wd[cyc+1] = d;
        mdl[a] = d; rsp = 8'h4B; s = cyc + 2;
        send(d, 1'b0);
      end
    end
    respond(s, rsp, bp, dd, ovr);
  endtask

  initial begin
    int kind, st_before;
    logic [7:0] b;
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
    tx_busy = 1'b0; tx_done = 1'b0; m_txd = 8'h00;
    for (int i = 0; i < 256; i++) mdl[i] = 8'(i) ^ 8'hA5;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    chk("rst_addr",  reg_addr,  8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    rst_n = 1'b1;
    tick();

    // Write, then read back through the register file.
    do_frame(8'h57, 8'h12, 8'hA5, 0, 0, 0, 3, 0, 0);
    chk_int("wr_we_lat", last_we - last_n, 1);
    chk_int("wr_st_lat", last_st - last_n, 3);
    chk("wr_rsp", last_st_data, 8'h4B);
    do_frame(8'h57, 8'h34, 8'hC3, 1, 2, 0, 2, 0, 0);
    do_frame(8'h52, 8'h34, 8'h00, 0, 0, 0, 2, 0, 0);
    chk_int("rd_re_lat", last_re - last_n, 1);
    chk_int("rd_st_lat", last_st - last_n, 4);
    chk("rd_rsp", last_st_data, 8'hC3);

    // Unknown command and a bad byte while idle.
    do_frame(8'h00, 8'h00, 8'h00, 0, 0, 0, 2, 0, 0);
    chk_int("unk_st_lat", last_st - last_n, 2);
    chk("unk_rsp", last_st_data, 8'h3F);
    st_before = last_st;
    e_ferr[cyc+1] = 1'b1;
    send(8'h57, 1'b1);
    chk("idle_err_ferr", 8'(frame_err), 8'h01);
    chk("idle_err_busy", 8'(busy), 8'h00);

    // Timeouts, including a byte landing exactly on the timeout cycle.
    do_frame(8'h57, 8'h00, 8'h00, 0, 0, 0, 1, 0, 3);
    chk_int("tmo_no_start", last_st, st_before);
    do_frame(8'h52, 8'h01, 8'h00, 0, 0, 0, 1, 0, 0);
    chk("tmo_then_rd", last_st_data, 8'hA4);
    do_frame(8'h57, 8'h40, 8'h77, T, T, 0, 1, 0, 0);
    do_frame(8'h52, 8'h40, 8'h00, T, 0, 0, 1, 0, 0);
    chk("edge_gap_rd", last_st_data, 8'h77);
    do_frame(8'h57, 8'h41, 8'h00, 0, 0, 0, 1, 0, 4);
    do_frame(8'h52, 8'h41, 8'h00, 0, 0, 0, 1, 0, 1);
    do_frame(8'h57, 8'h41, 8'h99, 0, 0, 0, 1, 0, 2);

    // Backpressure plus overruns in WAIT_DONE and alongside tx_done.
    do_frame(8'h57, 8'h20, 8'h66, 0, 0, 50, 4, 3, 0);
    chk_int("bp_st_lat", last_st - last_n, 53);
    do_frame(8'h52, 8'h20, 8'h00, 0, 0, 0, 3, 2, 0);
    chk("ovr_rd", last_st_data, 8'h66);

    // Reset in the middle of a write frame.
    in_frame = 1'b1;
    send(8'h57, 1'b0);
    send(8'h10, 1'b0);
    rst_n = 1'b0; in_frame = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_addr",  reg_addr,  8'h00);
    chk("midrst_wdata", reg_wdata, 8'h00);
    do_frame(8'h57, 8'h10, 8'h55, 0, 0, 0, 2, 0, 0);
    do_frame(8'h52, 8'h10, 8'h00, 0, 0, 0, 2, 0, 0);
    chk("midrst_rd", last_st_data, 8'h55);

    // Random frame mix.
    for (int it = 0; it < 150; it++) begin
      kind = int'($urandom_range(9, 0));
      if (kind <= 3)
        do_frame(8'h57, 8'($urandom_range(7, 0)), 8'($urandom), int'($urandom_range(T, 0)),
                 int'($urandom_range(T, 0)), int'($urandom_range(4, 0)), int'($urandom_range(5, 1)),
                 int'($urandom_range(3, 0)), 0);
      else if (kind <= 6)
        do_frame(8'h52, (kind == 6) ? 8'($urandom) : 8'($urandom_range(7, 0)), 8'h00,
                 int'($urandom_range(T, 0)), 0, int'($urandom_range(4, 0)),
                 int'($urandom_range(5, 1)), int'($urandom_range(3, 0)), 0);
      else if (kind == 7) begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        do_frame(b, 8'h00, 8'h00, 0, 0, int'($urandom_range(4, 0)), int'($urandom_range(5, 1)),
                 int'($urandom_range(3, 0)), 0);
      end else if (kind == 8) begin
        e_ferr[cyc+1] = 1'b1;
        send(8'($urandom), 1'b1);
      end else
        do_frame(8'h57, 8'($urandom_range(7, 0)), 8'($urandom), int'($urandom_range(T, 0)),
                 int'($urandom_range(T, 0)), 0, 1, 0, int'($urandom_range(4, 1)));
      idle(int'($urandom_range(3, 0)));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Responder end of the team's UART link: the UART supplies the physical layer, and this block supplies the command layer.
- Consumes received bytes from a UART receiver (rx_data/rx_valid/rx_error) and parses host command frames.
- Performs single-byte register reads and writes on a simple local bus.
- Returns one response byte per frame through a UART transmitter (tx_start/tx_data/tx_busy/tx_done).
- Sits between the uart module and an 8-bit register file.

Parameters:
- TIMEOUT_CYCLES, 1024, maximum idle clk cycles between bytes of one frame before the frame is aborted. Minimum 2.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- rx_data  input  8  received byte; valid when rx_valid=1.
- rx_valid  input  1  one-cycle pulse per received byte.
- rx_error  input  1  stop-bit error flag, qualified by rx_valid.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  output  8  response byte; held stable from tx_start until tx_done.
- tx_busy  input  1  transmitter busy.
- tx_done  input  1  one-cycle pulse when the transmitter finishes a byte.
- reg_addr  output  8  register address.
- reg_wdata  output  8  register write data.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data; valid in the cycle after reg_re.
- busy  output  1  high whenever the FSM is not in IDLE.
- frame_err  output  1  one-cycle pulse on an aborted frame or a dropped byte.

Behaviour:
- Frame format:
  - Write: 0x57 ('W'), addr, data. Response 0x4B ('K').
  - Read: 0x52 ('R'), addr. Response is the register contents.
  - Any other first byte: response 0x3F ('?'), no register access.
- All outputs are registered.
- Reset (rst_n=0 at a clock edge):
  - State returns to IDLE and the timeout counter clears.
  - tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy and frame_err all go to 0.
  - Reset overrides any in-flight frame; no response is sent.
- States: IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_CAP, SEND, WAIT_DONE.
- IDLE, on rx_valid:
  - rx_error=1: drop the byte, pulse frame_err, stay in IDLE.
  - 0x57 or 0x52: latch the command, go to GET_ADDR.
  - Any other byte: load response 0x3F, go to SEND.
- GET_ADDR, on a good byte: latch reg_addr.
  - Write command: go to GET_DATA.
  - Read command: go to REG_RD.
- GET_DATA, on a good byte: latch reg_wdata, go to REG_WR.
- Timeout (GET_ADDR and GET_DATA only):
  - The counter clears on entry and on every accepted byte, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: pulse frame_err, go to IDLE, send no response.
  - If rx_valid and the timeout occur in the same cycle, the byte is accepted and the timeout is ignored.
- rx_error in GET_ADDR or GET_DATA: pulse frame_err, go to IDLE, no response, no register access.
- REG_WR: reg_we=1 for exactly one cycle with stable reg_addr and reg_wdata. Load response 0x4B, go to SEND.
- REG_RD: reg_re=1 for exactly one cycle, go to RD_CAP.
- RD_CAP: capture reg_rdata as the response, go to SEND.
- SEND: wait while tx_busy=1. In the first cycle with tx_busy=0, the next cycle has tx_start=1 (single cycle) with tx_data=response; go to WAIT_DONE.
- WAIT_DONE: on tx_done, go to IDLE. tx_data holds its value until the next load.
- Overrun: rx_valid in REG_WR, REG_RD, RD_CAP, SEND or WAIT_DONE drops the byte and pulses frame_err. This includes a byte arriving in the same cycle as tx_done.
- Latency, with the final frame byte's rx_valid in cycle N and tx_busy=0:
  - Write: reg_we in N+1, tx_start in N+3.
  - Read: reg_re in N+1, reg_rdata sampled in N+2, tx_start in N+4.
  - Unknown command: tx_start in N+2.
- Only one frame is outstanding at a time. There is no byte buffering.

Test Plan:
- Write: send 0x57, 0x12, 0xA5 -> reg_we high for exactly 1 cycle with reg_addr=0x12, reg_wdata=0xA5; then one tx_start with tx_data=0x4B; busy returns to 0 after tx_done.
- Read: send 0x52, 0x34; drive reg_rdata=0xC3 in the cycle after reg_re -> reg_re high for 1 cycle with reg_addr=0x34; tx_data=0xC3; reg_we never asserts.
- Unknown and error handling: send 0x00 -> tx_data=0x3F, no reg strobes. Send 0x57 with rx_error=1 -> frame_err pulse, no tx_start, state stays IDLE.
- Timeout: send 0x57, then no bytes for TIMEOUT_CYCLES -> frame_err pulse, no reg_we, no tx_start. Then send 0x52, 0x01 -> a normal read completes.
- Backpressure and overrun: hold tx_busy=1 for 50 cycles at SEND -> tx_start fires exactly 1 cycle after tx_busy falls. A byte pulsed during WAIT_DONE -> frame_err, byte ignored.
- Reset mid-frame: after 0x57, 0x10, assert rst_n=0 for 1 cycle -> all outputs 0 at the next edge, no reg_we. A following 0x57, 0x10, 0x55 writes correctly.
